// File: rtl/fanin_8to1_rr_arb_if.sv
// Request/grant bundle between the fanout stage and the 8-to-1 round-robin arbiter.
// The master drives requests and the release strobe; the slave returns the grant.
interface fanin_8to1_rr_arb_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );
endinterface

// File: rtl/fanin_8to1_rr_arb.sv
// Round-robin 8-to-1 arbiter with release handshake and hold timeout.
// A grant is always followed by one idle cycle before the next grant is issued.
module fanin_8to1_rr_arb #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fanin_8to1_rr_arb_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       ptr_q, ptr_d;

  logic [2:0] win_id;
  logic       win_found;
  logic [2:0] idx;
  logic       at_limit;
  logic       owner_req;

  // Search ptr, ptr+1, ... (mod 8); first set request wins.
  always_comb begin
    win_id    = ptr_q;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!win_found && bus.req[idx]) begin
        win_id    = idx;
        win_found = 1'b1;
      end
    end
  end

  assign at_limit  = (hold_cnt_q == CNT_W'(HOLD_MAX));
  assign owner_req = bus.req[gnt_id_q];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d      = 8'b1 << win_id;
          gnt_id_d   = win_id;
          hold_cnt_d = CNT_W'(1);
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (bus.done || !owner_req || at_limit) begin
          // done outranks the timeout, so the pulse fires only on a pure hold-limit release.
          timeout_d  = !bus.done && owner_req && at_limit;
          gnt_d      = '0;
          ptr_d      = gnt_id_q + 3'd1;
          hold_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_fanin_8to1_rr_arb.sv
// Directed plus randomized bench for fanin_8to1_rr_arb against a cycle-level reference model.
module tb_fanin_8to1_rr_arb;
  localparam int HoldMax = 15;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model state, expressed as plain integers.
  bit m_busy;
  int m_id;
  int m_hold;
  int m_ptr;
  bit m_to;

  fanin_8to1_rr_arb_if bus ();

  fanin_8to1_rr_arb #(
    .HOLD_MAX (HoldMax),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_hold = 0; m_ptr = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    if (!m_busy) begin
      m_to = 0;
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_busy && r[(m_ptr + k) % 8]) begin
            m_id   = (m_ptr + k) % 8;
            m_busy = 1;
            m_hold = 1;
          end
        end
      end
    end else if (d) begin
      m_to = 0; m_busy = 0; m_ptr = (m_id + 1) % 8; m_hold = 0;
    end else if (!r[m_id]) begin
      m_to = 0; m_busy = 0; m_ptr = (m_id + 1) % 8; m_hold = 0;
    end else if (m_hold == HoldMax) begin
      m_to = 1; m_busy = 0; m_ptr = (m_id + 1) % 8; m_hold = 0;
    end else begin
      m_to = 0; m_hold = m_hold + 1;
    end
  endtask

  task automatic check_outputs();
    chk("gnt", {24'b0, bus.gnt}, m_busy ? (32'd1 << m_id) : 32'd0);
    chk("gnt_valid", {31'b0, bus.gnt_valid}, {31'b0, m_busy});
    chk("gnt_id", {29'b0, bus.gnt_id}, m_id);
    chk("timeout", {31'b0, bus.timeout}, {31'b0, m_to});
    chk("onehot", ($countones(bus.gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks at the next fall.
  task automatic tick(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       d;
    int         n_g0;
    int         n_to;
    int         seq_ok;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();

    // Reset, then idle with no requests.
    do_reset();
    for (int i = 0; i < 5; i++) tick(8'h00, 1'b0);

    // Single request: grant visible next cycle, held until done.
    tick(8'h04, 1'b0);
    chk("single_gnt", {24'b0, bus.gnt}, 32'h04);
    tick(8'h04, 1'b0);
    chk("single_gnt_id", {29'b0, bus.gnt_id}, 32'd2);
    tick(8'h04, 1'b1);
    chk("single_release", {24'b0, bus.gnt}, 32'h00);
    // ptr is now 3: with all lines requesting, line 3 must win.
    tick(8'hFF, 1'b0);
    chk("ptr_after_release", {29'b0, bus.gnt_id}, 32'd3);
    tick(8'hFF, 1'b1);
    tick(8'h00, 1'b0);

    // Round-robin rotation from a fresh reset: 0,1,...,7,0 with idle gaps.
    do_reset();
    seq_ok = 1;
    for (int g = 0; g < 9; g++) begin
      tick(8'hFF, 1'b0);
      if (bus.gnt_id !== 3'(g % 8) || bus.gnt_valid !== 1'b1) seq_ok = 0;
      tick(8'hFF, 1'b1);
      if (bus.gnt_valid !== 1'b0) seq_ok = 0;
    end
    chk("rotation_seq", seq_ok, 32'd1);
    tick(8'h00, 1'b0);

    // Hold timeout: bit0 held 15 cycles, one timeout pulse, then bit7.
    do_reset();
    n_g0 = 0;
    n_to = 0;
    for (int i = 0; i < 17; i++) begin
      tick(8'h81, 1'b0);
      if (bus.gnt === 8'h01) n_g0++;
      if (bus.timeout === 1'b1) n_to++;
    end
    chk("timeout_hold_len", n_g0, 32'd15);
    chk("timeout_pulses", n_to, 32'd1);
    chk("after_timeout_gnt", {24'b0, bus.gnt}, 32'h80);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);

    // done on the 15th held cycle beats the timeout.
    do_reset();
    for (int i = 0; i < 15; i++) tick(8'h81, 1'b0);
    chk("limit_cycle_gnt", {24'b0, bus.gnt}, 32'h01);
    tick(8'h81, 1'b1);
    chk("done_vs_timeout_to", {31'b0, bus.timeout}, 32'd0);
    chk("done_vs_timeout_gnt", {24'b0, bus.gnt}, 32'h00);
    tick(8'h81, 1'b0);
    chk("done_vs_timeout_next", {29'b0, bus.gnt_id}, 32'd7);
    tick(8'h00, 1'b0);

    // Asynchronous reset mid-grant clears the grant without a clock edge.
    do_reset();
    tick(8'h21, 1'b0);
    tick(8'h21, 1'b1);
    tick(8'h20, 1'b0);
    chk("pre_async_gnt", {24'b0, bus.gnt}, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", {24'b0, bus.gnt}, 32'h00);
    chk("async_rst_valid", {31'b0, bus.gnt_valid}, 32'd0);
    chk("async_rst_id", {29'b0, bus.gnt_id}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h20, 1'b0);
    chk("post_async_gnt", {24'b0, bus.gnt}, 32'h20);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);

    // Randomized phase: slowly changing requests, occasional done strobes.
    r = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 13) == 0) r[b] = ~r[b];
      end
      d = ($urandom_range(0, 24) == 0);
      tick(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
